// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble control for the decode-to-ALU register; define STALL_CNT_EN to enable stallCount
module pipe_hazard_ctrl #(
  parameter int OPCODE_W = 7,
  parameter int REG_W = 5,
  parameter logic [OPCODE_W-1:0] LOAD_OPCODE = 7'b0000011,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opCodeEx,
  input  logic [REG_W-1:0]    writeBackAddrEx,
  input  logic [REG_W-1:0]    dataS1AddrDec,
  input  logic [REG_W-1:0]    dataS2AddrDec,
  input  logic                useS1Dec,
  input  logic                useS2Dec,
  input  logic                mcReqDec,
  input  logic                mcDone,
  input  logic                memBusy,
  input  logic                flush,
  output logic                locker,
  output logic                bubble,
  output logic                pcHold,
  output logic                ifIdHold,
  output logic                mcStart,
  output logic                mcErr,
  output logic [31:0]         stallCount
);
  localparam int CW = $clog2(MC_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN = 2'b00, MC_WAIT = 2'b01, MC_DRAIN = 2'b10} state_e;
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_seen_q, done_seen_d;
  logic           err_q, err_d;
  logic           lu_haz, lock, bub, pc_h, ifid_h, start;
  assign lu_haz = opCodeEx == LOAD_OPCODE && writeBackAddrEx != '0 &&
                  ((useS1Dec && dataS1AddrDec == writeBackAddrEx) ||
                   (useS2Dec && dataS2AddrDec == writeBackAddrEx));
  // next-state and unforced pipeline controls from state plus hazard inputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_seen_d = done_seen_q;
    err_d       = err_q;
    lock        = 1'b1;
    bub         = 1'b0;
    pc_h        = 1'b0;
    ifid_h      = 1'b0;
    start       = 1'b0;
    case (state_q)
      RUN: begin
        if (memBusy) begin
          lock   = 1'b0;
          pc_h   = 1'b1;
          ifid_h = 1'b1;
        end else if (flush) begin
          bub = 1'b1;
        end else if (lu_haz) begin
          bub    = 1'b1;
          pc_h   = 1'b1;
          ifid_h = 1'b1;
        end else if (mcReqDec) begin
          start   = 1'b1;
          lock    = 1'b0;
          pc_h    = 1'b1;
          ifid_h  = 1'b1;
          state_d = MC_WAIT;
          cnt_d   = '0;
        end
      end
      MC_WAIT: begin
        cnt_d  = cnt_q + CW'(cnt_q != CNT_LAST);
        lock   = 1'b0;
        pc_h   = 1'b1;
        ifid_h = 1'b1;
        if (memBusy) begin
          if (mcDone) begin
            done_seen_d = 1'b1;
            state_d     = MC_DRAIN;
          end
        end else if (flush || mcDone || cnt_q == CNT_LAST) begin
          lock    = 1'b1;
          bub     = flush || !mcDone;
          pc_h    = 1'b0;
          ifid_h  = 1'b0;
          err_d   = err_q || (!flush && !mcDone);
          state_d = RUN;
        end
      end
      MC_DRAIN: begin
        lock   = 1'b0;
        pc_h   = 1'b1;
        ifid_h = 1'b1;
        if (!memBusy && done_seen_q) begin
          lock        = 1'b1;
          bub         = flush;
          pc_h        = 1'b0;
          ifid_h      = 1'b0;
          done_seen_d = 1'b0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end
  // reset fills the pipeline with NOPs while holding the PC
  assign locker   = !reset || lock;
  assign bubble   = !reset || bub;
  assign pcHold   = !reset || pc_h;
  assign ifIdHold = reset && ifid_h;
  assign mcStart  = reset && start;
  assign mcErr    = err_q;
  // controller state; async reset abandons any outstanding multi-cycle op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      done_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_seen_q <= done_seen_d;
      err_q       <= err_d;
    end
  end
`ifdef STALL_CNT_EN
  logic [31:0] stall_q;
  // saturating count of held or bubbled cycles; reset holds it at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_q + 32'((stall_q != '1) && (!locker || bubble));
  end
  assign stallCount = stall_q;
`else
  assign stallCount = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opCodeEx;
  logic [4:0]  writeBackAddrEx, dataS1AddrDec, dataS2AddrDec;
  logic        useS1Dec, useS2Dec, mcReqDec, mcDone, memBusy, flush;
  logic        locker, bubble, pcHold, ifIdHold, mcStart, mcErr;
  logic [31:0] stallCount;
  logic [4:0]  outs;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_start = 0;
  int          s0;

  pipe_hazard_ctrl #(.MC_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .opCodeEx(opCodeEx), .writeBackAddrEx(writeBackAddrEx),
    .dataS1AddrDec(dataS1AddrDec), .dataS2AddrDec(dataS2AddrDec), .useS1Dec(useS1Dec),
    .useS2Dec(useS2Dec), .mcReqDec(mcReqDec), .mcDone(mcDone), .memBusy(memBusy),
    .flush(flush), .locker(locker), .bubble(bubble), .pcHold(pcHold), .ifIdHold(ifIdHold),
    .mcStart(mcStart), .mcErr(mcErr), .stallCount(stallCount)
  );

  always #5 clk = ~clk;
  assign outs = {locker, bubble, pcHold, ifIdHold, mcStart};
  always @(negedge clk) n_start += int'(mcStart);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; opCodeEx = '0; writeBackAddrEx = '0; dataS1AddrDec = '0; dataS2AddrDec = '0;
    useS1Dec = 0; useS2Dec = 0; mcReqDec = 1; mcDone = 0; memBusy = 1; flush = 0;
    #3;
    check("rst_outs", 32'(outs), 32'b11100);
    check("rst_err", 32'(mcErr), 0);
    check("rst_cnt", stallCount, 0);
    tick; tick;
    reset = 1'b1; mcReqDec = 0; memBusy = 0;
    #3 check("run_idle", 32'(outs), 32'b10000);
    tick;
    opCodeEx = 7'b0000011; writeBackAddrEx = 5; dataS1AddrDec = 5; useS1Dec = 1;
    #3 check("lu_rs1", 32'(outs), 32'b11110);
    tick;
    opCodeEx = '0;
    #3 check("lu_after", 32'(outs), 32'b10000);
    tick;
    opCodeEx = 7'b0000011; writeBackAddrEx = 0; dataS1AddrDec = 0;
    #3 check("lu_rd0", 32'(outs), 32'b10000);
    tick;
    opCodeEx = '0; useS1Dec = 0; s0 = n_start; mcReqDec = 1;
    #3 check("mc_start", 32'(outs), 32'b00111);
    for (int i = 0; i < 3; i++) begin
      tick;
      #3 check("mc_wait", 32'(outs), 32'b00110);
    end
    tick;
    mcDone = 1;
    #3 check("mc_done", 32'(outs), 32'b10000);
    tick;
    mcDone = 0; mcReqDec = 0;
    #3 check("mc_back", 32'(outs), 32'b10000);
    check("mc_starts", 32'(n_start - s0), 1);
`ifdef STALL_CNT_EN
    check("stall_cnt", stallCount, 5);
`else
    check("stall_cnt", stallCount, 0);
`endif
    tick;
    opCodeEx = 7'b0000011; writeBackAddrEx = 7; dataS2AddrDec = 7; useS2Dec = 1;
    #3 check("lu_rs2", 32'(outs), 32'b11110);
    useS2Dec = 0;
    #1 check("lu_nouse", 32'(outs), 32'b10000);
    tick;
    useS2Dec = 1; memBusy = 1; mcReqDec = 1;
    #3 check("run_busy", 32'(outs), 32'b00110);
    memBusy = 0; flush = 1;
    #1 check("run_flush", 32'(outs), 32'b11000);
    tick;
    flush = 0; useS2Dec = 0; opCodeEx = '0; s0 = n_start;
    #3 check("dr_start", 32'(outs), 32'b00111);
    tick;
    memBusy = 1; mcDone = 1;
    #3 check("dr_wait", 32'(outs), 32'b00110);
    tick;
    mcDone = 0;
    #3 check("dr_hold", 32'(outs), 32'b00110);
    tick;
    memBusy = 0;
    #3 check("dr_rel", 32'(outs), 32'b10000);
    tick;
    mcReqDec = 0;
    #3 check("dr_run", 32'(outs), 32'b10000);
    check("dr_starts", 32'(n_start - s0), 1);
    tick;
    mcReqDec = 1;
    #3 check("fl_start", 32'(outs), 32'b00111);
    tick;
    #3 check("fl_wait", 32'(outs), 32'b00110);
    tick;
    flush = 1;
    #3 check("fl_rel", 32'(outs), 32'b11000);
    tick;
    flush = 0; mcReqDec = 0; mcDone = 1;
    #3 check("fl_late", 32'(outs), 32'b10000);
    tick;
    mcDone = 0; mcReqDec = 1;
    #3 check("to_start", 32'(outs), 32'b00111);
    for (int i = 0; i < 7; i++) begin
      tick;
      #3 check("to_wait", 32'(outs), 32'b00110);
    end
    tick;
    #3 check("to_rel", 32'(outs), 32'b11000);
    check("to_err_pre", 32'(mcErr), 0);
    tick;
    mcReqDec = 0;
    #3 check("to_err", 32'(mcErr), 1);
    check("to_run", 32'(outs), 32'b10000);
    tick; tick;
    #3 check("to_sticky", 32'(mcErr), 1);
    reset = 0;
    #1 check("to_clr", 32'(mcErr), 0);
    tick;
    reset = 1; mcReqDec = 1;
    #3 check("ar_start", 32'(outs), 32'b00111);
    tick;
    mcReqDec = 0;
    #1 reset = 0;
    #1 check("ar_outs", 32'(outs), 32'b11100);
    tick;
    reset = 1; mcDone = 1;
    #3 check("ar_late", 32'(outs), 32'b10000);
    tick;
    mcDone = 0;
    #3 check("ar_run", 32'(outs), 32'b10000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall and bubble controller for the decode-to-ALU pipeline register.
- Drives that register's `locker` load strobe, a NOP-bubble select, and the PC and IF/ID hold lines.
- Sequences three cases: load-use hazards, multi-cycle (M-extension) ALU operations via a start/done handshake, and data-cache busy freezes.
- Sits beside the forwarding unit and consumes the ALU-stage opcode and destination register.

Parameters:
- OPCODE_W, 7, opcode width.
- REG_W, 5, register address width.
- LOAD_OPCODE, 7'b0000011, opcode value that causes a load-use hazard.
- MC_TIMEOUT, 64, maximum number of MC_WAIT cycles before abort; must be ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opCodeEx  in  OPCODE_W  opcode of the instruction now in the ALU stage.
- writeBackAddrEx  in  REG_W  rd of the ALU-stage instruction.
- dataS1AddrDec  in  REG_W  rs1 of the decode-stage instruction.
- dataS2AddrDec  in  REG_W  rs2 of the decode-stage instruction.
- useS1Dec  in  1  decode instruction reads rs1.
- useS2Dec  in  1  decode instruction reads rs2.
- mcReqDec  in  1  decode instruction is a multi-cycle operation.
- mcDone  in  1  multi-cycle unit result valid; single-cycle pulse.
- memBusy  in  1  data cache cannot accept or return this cycle.
- flush  in  1  branch or jump redirect; squash the decode instruction.
- locker  out  1  1 = decode/ALU register loads, 0 = holds.
- bubble  out  1  1 = register loads a NOP (write enable 0, cache control idle).
- pcHold  out  1  freeze PC.
- ifIdHold  out  1  freeze the IF/ID register.
- mcStart  out  1  one-cycle start pulse to the multi-cycle unit.
- mcErr  out  1  sticky flag: timeout occurred.
- stallCount  out  32  stall/bubble cycle counter; feature-dependent.

Behaviour:
- States: RUN=2'b00, MC_WAIT=2'b01, MC_DRAIN=2'b10.
  - State register, timeout counter (width clog2(MC_TIMEOUT)+1), doneSeen, mcErr and stallCount are registered.
  - All other outputs are combinational from state plus inputs.
- While reset=0:
  - state=RUN, counter=0, doneSeen=0, mcErr=0, stallCount=0.
  - Outputs forced: locker=1, bubble=1, pcHold=1, ifIdHold=0, mcStart=0.
  - Effect: the pipeline fills with NOPs.
- Load-use detect (luHaz): opCodeEx==LOAD_OPCODE && writeBackAddrEx!=0 && ((useS1Dec && rs1==rd) || (useS2Dec && rs2==rd)).
- RUN, evaluated in this priority order:
  1. memBusy → locker=0, pcHold=1, ifIdHold=1, bubble=0.
  2. flush → locker=1, bubble=1, pcHold=0, ifIdHold=0. Any pending mcReqDec is discarded.
  3. luHaz → locker=1, bubble=1, pcHold=1, ifIdHold=1. This is exactly one stall cycle; the bubble clears luHaz on the next cycle.
  4. mcReqDec → mcStart=1, locker=0, pcHold=1, ifIdHold=1; next state MC_WAIT, counter cleared.
  5. Otherwise → locker=1, all holds 0, bubble=0.
- MC_WAIT:
  - Holds: locker=0, pcHold=1, ifIdHold=1. Counter increments each cycle.
  - mcDone and !memBusy → same-cycle release: locker=1, holds 0. Next state RUN; the op enters the ALU stage with its result.
  - mcDone and memBusy → set doneSeen; next state MC_DRAIN.
  - flush (memBusy=0) → locker=1, bubble=1, holds 0. Next state RUN. Any later mcDone is ignored.
  - Counter reaches MC_TIMEOUT-1 with no mcDone → mcErr<=1; release as bubble (locker=1, bubble=1); next state RUN.
- MC_DRAIN:
  - Holds until memBusy=0; then releases as in MC_WAIT done and returns to RUN, clearing doneSeen.
  - flush has priority, as in MC_WAIT.
- mcStart:
  - Never asserted twice for one instruction.
  - Never asserted outside RUN.
- mcErr is cleared only by reset.
- Asynchronous reset mid-MC_WAIT returns to RUN immediately. Any late mcDone is ignored.

Optional Feature:
- STALL_CNT_EN defined:
  - stallCount increments, saturating at 32'hFFFF_FFFF, on every post-reset cycle where locker==0 || bubble==1.
  - The reset-forced bubble does not count.
- STALL_CNT_EN undefined:
  - No counter logic; stallCount is tied to 0.

Test Plan:
- Load-use: opCodeEx=0000011, rd=5; decode rs1=5, useS1=1 → one cycle with locker=1, bubble=1, pcHold=1, ifIdHold=1. Next cycle all deasserted. Repeat with rd=0 → no stall.
- Multi-cycle: mcReqDec=1 in RUN → mcStart high for one cycle; locker=0 for 3 cycles; mcDone on cycle 4 → locker=1 that cycle; back in RUN.
- mcDone arrives while memBusy=1 → MC_DRAIN. Release occurs the cycle memBusy falls; exactly one mcStart observed in total.
- flush during MC_WAIT → locker=1, bubble=1 that cycle; state RUN. A subsequent mcDone pulse produces no output change.
- Timeout with MC_TIMEOUT=8 and no mcDone → after 8 MC_WAIT cycles mcErr=1 and a bubble is released. mcErr stays 1 until reset=0.
- With STALL_CNT_EN: scenarios 1+2 run back to back → stallCount=5 (1 load-use bubble plus 4 multi-cycle hold cycles: the mcStart cycle and the 3 MC_WAIT hold cycles). Without STALL_CNT_EN → stallCount=0.
